mine_placer: RTL

Upstream stage of the minesweeper datapath: on a `start` pulse it places a requested number of distinct mines on the 5x5 board (cells 0..24) and presents the 25-bit `mines` vector, with a `place_done` level, to the datapath's start/load path. Positions come from a free-running 16-bit Galois LFSR using rejection sampling. A deterministic fallback fill guarantees bounded latency.

---
 rtl/mine_placer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mine_placer.sv
// Places a requested number of distinct mines on a 5x5 board using rejection
// sampling from a free-running Galois LFSR, with a deterministic fallback fill.
module mine_placer #(
    parameter logic [15:0] TAPS         = 16'hB400,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
    parameter logic [7:0]  MAX_TRIES    = 8'd200
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        start,
    input  logic [4:0]  mines_num,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [24:0] mines,
    output logic        place_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, DRAW, FILL} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_step;
    logic [4:0]  target_q, target_d;
    logic [4:0]  count_q, count_d;
    logic [7:0]  tries_q, tries_d;
    logic [24:0] mines_q, mines_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [4:0]  cand;
    logic [31:0] cand_onehot;
    logic [24:0] cand_bit;
    logic        cand_ok;
    logic [24:0] fill_bit;

    assign lfsr_step   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
    assign cand        = lfsr_q[4:0];
    assign cand_onehot = 32'd1 << cand;
    assign cand_bit    = cand_onehot[24:0];
    assign cand_ok     = (cand < 5'd25) && ((mines_q & cand_bit) == 25'd0);
    // Lowest zero bit as a one-hot: the +1 carry stops exactly at the first zero.
    assign fill_bit    = ~mines_q & (mines_q + 25'd1);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        tries_d  = tries_q;
        mines_d  = mines_q;
        done_d   = done_q;
        lfsr_d   = seed_load ? ((seed == 16'h0000) ? SEED_DEFAULT : seed) : lfsr_step;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = (mines_num > 5'd24) ? 5'd24 : mines_num;
                    mines_d  = '0;
                    count_d  = '0;
                    tries_d  = '0;
                    done_d   = 1'b0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (count_q == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cand_ok) begin
                    mines_d = mines_q | cand_bit;
                    count_d = count_q + 5'd1;
                    tries_d = '0;
                end else begin
                    tries_d = tries_q + 8'd1;
                    if (tries_q == MAX_TRIES - 8'd1) state_d = FILL;
                end
            end
            FILL: begin
                if (count_q == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    mines_d = mines_q | fill_bit;
                    count_d = count_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(negedge clka or posedge restart) begin
        if (restart) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_DEFAULT;
            target_q <= '0;
            count_q  <= '0;
            tries_q  <= '0;
            mines_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            count_q  <= count_d;
            tries_q  <= tries_d;
            mines_q  <= mines_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign mines      = mines_q;
    assign place_done = done_q;
    assign busy       = busy_q;

endmodule
